bcd_mux_display: RTL
====================

BCD_MUX_DISPLAY -- requirements
Module: bcd_mux_display

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits counted and displayed, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles per scanned digit, legal range 2 or more.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_syn, input, 1: reset, asynchronous, active-low.
REQ-005 Port load_syn, input, 1: parallel load strobe, sampled on clk.
REQ-006 Port Din, input, 4*DIGITS: load value; Din[3:0] is the least significant digit.
REQ-007 Port en, input, 1: count enable.
REQ-008 Port up, input, 1: direction; 1 counts up, 0 counts down.
REQ-009 Port bcd_q, output, 4*DIGITS: registered counter value in BCD.
REQ-010 Port tc, output, 1: terminal-count pulse.
REQ-011 Port load_err, output, 1: invalid-load pulse.
REQ-012 Port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low (common anode).
REQ-013 Port an, output, DIGITS: one-hot digit select, active-low; an[0] selects the least significant digit.

Function
REQ-014 Load SHALL take priority: load_syn=1 at an edge sets bcd_q to Din on that edge, regardless of en.
REQ-015 On load, any Din digit greater than 9 SHALL be stored as 0, and load_err SHALL be 1 for exactly the following cycle.
REQ-016 With load_syn=0 and en=1, bcd_q SHALL change by +1 (up=1) or -1 (up=0) per edge, with a decimal carry or borrow between digits.
REQ-017 Wrap-around: counting up from all-9s SHALL give all-0s, and counting down from all-0s SHALL give all-9s.
REQ-018 tc SHALL be 1 for exactly the cycle in which bcd_q shows the wrapped value; a load SHALL never raise tc.
REQ-019 With en=0 and load_syn=0, bcd_q SHALL hold its value.
REQ-020 Scan behaviour:
- A prescaler SHALL count 0..REFRESH_DIV-1.
- At its terminal value, the scan index SHALL advance 0,1,..,DIGITS-1 and then wrap to 0.
REQ-021 an and seg SHALL be registered and updated on the same edge, so they are always aligned.
REQ-022 seg SHALL show the digit of the current bcd_q selected by the scan index, with one cycle of latency from a bcd_q change.
REQ-023 Segment patterns (active-low) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-024 Load or count activity SHALL NOT disturb the prescaler or the scan index.

Reset
REQ-025 While rst_syn=0, asynchronously and independent of clk, the block SHALL hold:
- bcd_q=0, prescaler=0, scan index=0
- tc=0, load_err=0
- an with only bit 0 low, seg=1000000
REQ-026 Reset asserted mid-count or mid-scan SHALL abandon all state; the first edge after release SHALL behave as from the reset values.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN, when defined: any digit above the most significant nonzero digit SHALL drive seg=1111111 while it is scanned; digit 0 SHALL never blank.
REQ-028 Macro LEADING_ZERO_BLANK_EN, when undefined: every digit SHALL be displayed, including leading zeros.

Structure
REQ-029 Shared package bcd_pkg SHALL hold:
- the segment lookup constants and SEG_BLANK
- the 4-bit BCD digit typedef
- the digit-to-segment decode function
REQ-030 Sub-module bcd_digit SHALL implement one digit counter (load, carry/borrow in and out) and SHALL be generate-instantiated DIGITS times.

Verification (DIGITS=4, REFRESH_DIV=4)
REQ-031 Reset: rst_syn low then high -> bcd_q=0000, an=1110, seg=1000000, tc=0.
REQ-032 Load and count up: load Din=0x0995, then en=1, up=1 for 6 cycles -> bcd_q sequence 0996, 0997, 0998, 0999, 1000, 1001, tc=0.
REQ-033 Wrap and priority:
- load 9999, then en=1, up=1 -> bcd_q=0000 with tc=1 for one cycle.
- load 0000, then up=0 -> bcd_q=9999 with tc=1.
- load_syn and en together -> load wins.
REQ-034 Invalid load: Din=0x5A3F -> bcd_q=5030 and load_err=1 for one cycle.
REQ-035 Scan: bcd_q=1234 held -> an steps 1110, 1101, 1011, 0111 every 4 cycles, with seg showing 4, 3, 2, 1; the wrap back to 1110 is checked.
REQ-036 Blanking and async reset:
- with LEADING_ZERO_BLANK_EN and bcd_q=0007, digits 3..1 show 1111111 and digit 0 shows 1111000.
- rst_syn pulsed low between clk edges -> outputs reset immediately.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types, seven-segment lookup constants and the digit decoder.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef logic [BCD_W-1:0] bcd_digit_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Active-low {g,f,e,d,c,b,a} patterns for a common-anode display
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic logic bcd_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

  function automatic seg_t bcd_to_seg(input bcd_digit_t d);
    seg_t s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD up/down counter: parallel load with invalid-digit
// scrubbing, carry/borrow in from the lower decade and out to the next.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  bcd_digit_t din_i,
  input  logic       cin_i,
  input  logic       up_i,
  output bcd_digit_t q_o,
  output logic       cout_c,
  output logic       din_inv_c
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  assign din_inv_c = ~bcd_valid(din_i);

  // Carry/borrow ripples only when this decade is at its rollover value
  assign cout_c = cin_i & (up_i ? (q_q == BCD_MAX) : (q_q == BCD_MIN));

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = din_inv_c ? BCD_MIN : din_i;
    end else if (cin_i) begin
      if (up_i) begin
        q_d = (q_q == BCD_MAX) ? BCD_MIN : bcd_digit_t'(q_q + 4'd1);
      end else begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : bcd_digit_t'(q_q - 4'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bcd_mux_display.sv
// Multi-digit BCD up/down counter driving a time-multiplexed common-anode
// seven-segment display. Optional: LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_mux_display
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_syn,
  input  logic                  load_syn,
  input  logic [4*DIGITS-1:0]   Din,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   bcd_q,
  output logic                  tc,
  output logic                  load_err,
  output logic [SEG_W-1:0]      seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RST   = ~DIGITS'(1);

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] din_inv;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tc_q, tc_d;
  logic              load_err_q, load_err_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg_t              seg_q, seg_d;

  bcd_digit_t        cur_digit;
  logic              cur_blank;

  assign carry[0] = en;

  // Ripple chain: decade i steps when every lower decade rolls over
  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_dig
    bcd_digit u_dig (
      .clk       (clk),
      .rst_n     (rst_syn),
      .load_i    (load_syn),
      .din_i     (Din[4*i +: 4]),
      .cin_i     (carry[i]),
      .up_i      (up),
      .q_o       (bcd_q[4*i +: 4]),
      .cout_c    (carry[i+1]),
      .din_inv_c (din_inv[i])
    );
  end

  // Wrap of the whole counter, suppressed on a load edge
  always_comb begin
    tc_d       = ~load_syn & carry[DIGITS];
    load_err_d = load_syn & (|din_inv);
  end

  // Free-running scan timebase, independent of counter activity
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : IDX_W'(idx_q + 1'b1);
    end else begin
      presc_d = PRE_W'(presc_q + 1'b1);
    end
  end

  always_comb begin
    cur_digit = BCD_MIN;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = bcd_q[4*i +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;

  // Digit i is blank when it and every higher digit are zero; digit 0 never
  always_comb begin
    logic all_zero;
    lead_zero = '0;
    all_zero  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero     = all_zero & (bcd_q[4*i +: 4] == BCD_MIN);
      lead_zero[i] = all_zero;
    end
  end

  always_comb begin
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_blank = lead_zero[i];
      end
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  always_comb begin
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = cur_blank ? SEG_BLANK : bcd_to_seg(cur_digit);
  end

  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      presc_q    <= '0;
      idx_q      <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
      an_q       <= AN_RST;
      seg_q      <= SEG_0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign tc       = tc_q;
  assign load_err = load_err_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule
